// File: rtl/dsram_port_arbiter_if.sv
// Bundle of the two requester ports and the single data-SRAM port shared by dsram_port_arbiter.
// master: requesters plus SRAM side (drives requests and sram_rdata); slave: the arbiter.
interface dsram_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int BW = DW / 8;

    logic          m0_req;
    logic [BW-1:0] m0_wen;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_stallreq;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic [BW-1:0] m1_wen;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          sram_en;
    logic [BW-1:0] sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    modport master (
        output m0_req, m0_wen, m0_addr, m0_wdata,
        output m1_req, m1_wen, m1_addr, m1_wdata,
        output sram_rdata,
        input  m0_stallreq, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  sram_en, sram_wen, sram_addr, sram_wdata
    );

    modport slave (
        input  m0_req, m0_wen, m0_addr, m0_wdata,
        input  m1_req, m1_wen, m1_addr, m1_wdata,
        input  sram_rdata,
        output m0_stallreq, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata
    );
endinterface

// File: rtl/dsram_port_arbiter.sv
// Shares the data-SRAM port between the pipeline (m0) and a secondary master (m1).
// Define DSRAM_ROUND_ROBIN_EN for round-robin arbitration; default is m0 priority with m1 starvation guard.
module dsram_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 8
) (
    input logic                 clk,
    input logic                 rst,
    dsram_port_arbiter_if.slave bus
);
    localparam int BW = DW / 8;

    logic          gnt0;
    logic          gnt1;
    logic          rd_valid_q;
    logic          rd_id_q;
    logic [BW-1:0] wen_mux;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;

`ifdef DSRAM_ROUND_ROBIN_EN
    logic last_gnt_q;
`else
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] wait_cnt;
    logic          forced;

    assign forced = bus.m1_req && (wait_cnt == WW'(MAX_WAIT));
`endif

    // Grants are held off during reset so every output reads 0 while rst is high.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
`ifdef DSRAM_ROUND_ROBIN_EN
            if (bus.m0_req && bus.m1_req) begin
                gnt0 = last_gnt_q;
                gnt1 = !last_gnt_q;
            end else begin
                gnt0 = bus.m0_req;
                gnt1 = bus.m1_req;
            end
`else
            if (forced)
                gnt1 = 1'b1;
            else if (bus.m0_req)
                gnt0 = 1'b1;
            else
                gnt1 = bus.m1_req;
`endif
        end
    end

    always_comb begin
        wen_mux   = '0;
        addr_mux  = '0;
        wdata_mux = '0;
        if (gnt0) begin
            wen_mux   = bus.m0_wen;
            addr_mux  = bus.m0_addr;
            wdata_mux = bus.m0_wdata;
        end else if (gnt1) begin
            wen_mux   = bus.m1_wen;
            addr_mux  = bus.m1_addr;
            wdata_mux = bus.m1_wdata;
        end
    end

    assign bus.sram_en     = gnt0 | gnt1;
    assign bus.sram_wen    = wen_mux;
    assign bus.sram_addr   = addr_mux;
    assign bus.sram_wdata  = wdata_mux;
    assign bus.m0_stallreq = bus.m0_req && !gnt0 && !rst;
    assign bus.m1_gnt      = gnt1;

    // A response still in flight when reset arrives is dropped, not delivered.
    assign bus.m0_rvalid = rd_valid_q && !rd_id_q && !rst;
    assign bus.m1_rvalid = rd_valid_q && rd_id_q && !rst;
    assign bus.m0_rdata  = bus.m0_rvalid ? bus.sram_rdata : '0;
    assign bus.m1_rdata  = bus.m1_rvalid ? bus.sram_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
            rd_valid_q <= 1'b0;
            rd_id_q    <= 1'b0;
`ifdef DSRAM_ROUND_ROBIN_EN
            last_gnt_q <= 1'b1;
`else
            wait_cnt   <= '0;
`endif
        end else begin
            rd_valid_q <= (gnt0 && bus.m0_wen == '0) || (gnt1 && bus.m1_wen == '0);
            rd_id_q    <= gnt1 && bus.m1_wen == '0;
`ifdef DSRAM_ROUND_ROBIN_EN
            if (gnt0 || gnt1)
                last_gnt_q <= gnt1;
`else
            if (!bus.m1_req || gnt1)
                wait_cnt <= '0;
            else if (wait_cnt != WW'(MAX_WAIT))
                wait_cnt <= wait_cnt + 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_dsram_port_arbiter.sv
// Directed bench for dsram_port_arbiter: a small SRAM model behind the port and a
// scoreboard queue of expected read responses, checked every cycle.
module tb_dsram_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dsram_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    dsram_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    localparam logic [31:0] INIT [16] = '{
        32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003,
        32'hDEAD_BEEF, 32'h5555_0005, 32'h6666_0006, 32'h7777_0007,
        32'h8888_0008, 32'h9999_0009, 32'hAAAA_000A, 32'hBBBB_000B,
        32'hCCCC_000C, 32'hDDDD_000D, 32'hEEEE_000E, 32'hFFFF_000F
    };

    // SRAM model: byte writes in the enable cycle, registered read data one cycle later.
    logic [31:0] mem [16] = INIT;
    always @(posedge clk) begin
        if (bus.sram_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.sram_wen[b])
                    mem[bus.sram_addr[5:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
            if (bus.sram_wen == 4'h0)
                bus.sram_rdata <= mem[bus.sram_addr[5:2]];
        end
    end

    typedef struct {
        bit          id;
        logic [31:0] data;
        int          due;
    } exp_rd_t;

    exp_rd_t     exp_q [$];
    logic [31:0] ref_mem [16] = INIT;
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;
    bit          m1_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.m0_req = 1'b0; bus.m0_wen = 4'h0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_wen = 4'h0; bus.m1_addr = '0; bus.m1_wdata = '0;
    endtask

    task automatic m0_drive(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        bus.m0_req = 1'b1; bus.m0_wen = wen; bus.m0_addr = addr; bus.m0_wdata = wdata;
    endtask

    task automatic m1_drive(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        bus.m1_req = 1'b1; bus.m1_wen = wen; bus.m1_addr = addr; bus.m1_wdata = wdata;
    endtask

    task automatic push_rd(input bit id, input logic [31:0] addr);
        exp_rd_t e;
        e.id   = id;
        e.data = ref_mem[addr[5:2]];
        e.due  = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Sample at the falling edge and compare read responses against the scoreboard.
    task automatic eval();
        exp_rd_t e;
        @(negedge clk);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("rvalid_m0", bus.m0_rvalid, !e.id);
            check("rvalid_m1", bus.m1_rvalid, e.id);
            check("rdata_owner", e.id ? bus.m1_rdata : bus.m0_rdata, e.data);
            check("rdata_other", e.id ? bus.m0_rdata : bus.m1_rdata, 0);
        end else begin
            check("no_rvalid_m0", bus.m0_rvalid, 0);
            check("no_rvalid_m1", bus.m1_rvalid, 0);
            check("no_rdata_m0", bus.m0_rdata, 0);
            check("no_rdata_m1", bus.m1_rdata, 0);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        exp_q.delete();
        adv();
        adv();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sram_en"}, bus.sram_en, 0);
        check({tag, "_sram_wen"}, bus.sram_wen, 0);
        check({tag, "_sram_addr"}, bus.sram_addr, 0);
        check({tag, "_sram_wdata"}, bus.sram_wdata, 0);
        check({tag, "_stallreq"}, bus.m0_stallreq, 0);
        check({tag, "_m1_gnt"}, bus.m1_gnt, 0);
    endtask

    initial begin
        idle();
        bus.m0_req = 1'b1;
        bus.m1_req = 1'b1;
        bus.m0_addr = 32'h10;
        bus.m1_addr = 32'h14;

        // Reset state with both requesters active: everything must stay quiet.
        eval();
        check_all_zero("reset");
        adv();
        do_reset();

        // Single m0 read of 0xDEADBEEF.
        m0_drive(4'h0, 32'h10, '0);
        eval();
        check("rd_sram_en", bus.sram_en, 1);
        check("rd_sram_addr", bus.sram_addr, 32'h10);
        check("rd_stallreq", bus.m0_stallreq, 0);
        check("rd_sram_wen", bus.sram_wen, 0);
        push_rd(1'b0, 32'h10);
        adv();
        idle();
        eval();
        check("idle_sram_en", bus.sram_en, 0);
        check("idle_sram_addr", bus.sram_addr, 0);
        adv();

        // m0 partial write collides with an m1 read; m1 waits one cycle.
        do_reset();
        m0_drive(4'b0011, 32'h20, 32'hAABB_CCDD);
        m1_drive(4'h0, 32'h24, '0);
        eval();
        check("wr_m1_gnt", bus.m1_gnt, 0);
        check("wr_stallreq", bus.m0_stallreq, 0);
        check("wr_sram_en", bus.sram_en, 1);
        check("wr_sram_wen", bus.sram_wen, 4'b0011);
        check("wr_sram_addr", bus.sram_addr, 32'h20);
        check("wr_sram_wdata", bus.sram_wdata, 32'hAABB_CCDD);
        ref_mem[8][15:0] = 16'hCCDD;
        adv();
        bus.m0_req = 1'b0; bus.m0_wen = 4'h0; bus.m0_addr = '0; bus.m0_wdata = '0;
        eval();
        check("m1_late_gnt", bus.m1_gnt, 1);
        check("m1_late_addr", bus.sram_addr, 32'h24);
        push_rd(1'b1, 32'h24);
        adv();
        idle();
        m0_drive(4'h0, 32'h20, '0);
        eval();
        push_rd(1'b0, 32'h20);
        adv();
        idle();
        eval();
        adv();

        // Alternating reads on consecutive cycles: responses pipeline with no bubble.
        m0_drive(4'h0, 32'h04, '0);
        eval();
        push_rd(1'b0, 32'h04);
        adv();
        idle();
        m1_drive(4'h0, 32'h08, '0);
        eval();
        check("alt_m1_gnt", bus.m1_gnt, 1);
        push_rd(1'b1, 32'h08);
        adv();
        idle();
        m0_drive(4'h0, 32'h0C, '0);
        eval();
        push_rd(1'b0, 32'h0C);
        adv();
        idle();
        eval();
        adv();

`ifndef DSRAM_ROUND_ROBIN_EN
        // Starvation guard: m1 is forced through on its ninth requesting cycle.
        do_reset();
        m1_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            m0_drive(4'h0, 32'h10, '0);
            bus.m1_req = !m1_done; bus.m1_wen = 4'h0; bus.m1_addr = 32'h04;
            eval();
            check("starve_m1_gnt", bus.m1_gnt, k == 8);
            check("starve_stallreq", bus.m0_stallreq, k == 8);
            if (k == 8) begin
                check("starve_wait_max", dut.wait_cnt, 8);
                push_rd(1'b1, 32'h04);
                m1_done = 1'b1;
            end else begin
                push_rd(1'b0, 32'h10);
            end
            if (k == 9)
                check("starve_wait_clr", dut.wait_cnt, 0);
            adv();
        end
        idle();
        eval();
        adv();
`endif

        // Reset in the cycle after an m0 read grant drops the response.
        do_reset();
        m0_drive(4'h0, 32'h10, '0);
        eval();
        check("rstmid_grant", bus.sram_en, 1);
        adv();
        rst = 1'b1;
        exp_q.delete();
        m1_drive(4'h0, 32'h14, '0);
        eval();
        check_all_zero("rstmid");
        adv();
        rst = 1'b0;
        idle();
        eval();
        adv();

`ifdef DSRAM_ROUND_ROBIN_EN
        // Round robin with both requesting: m0 first, then strict alternation.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            m0_drive(4'h0, 32'h08, '0);
            m1_drive(4'h0, 32'h0C, '0);
            eval();
            check("rr_m1_gnt", bus.m1_gnt, (k % 2) == 1);
            check("rr_stallreq", bus.m0_stallreq, (k % 2) == 1);
            if ((k % 2) == 1)
                push_rd(1'b1, 32'h0C);
            else
                push_rd(1'b0, 32'h08);
            adv();
        end
        idle();
        eval();
        adv();
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
